lfsr_gen: RTL and testbench



---
 rtl/lfsr_pkg.sv | 179 +++++++++++++++++
 rtl/lfsr_step.sv | 28 ++
 rtl/lfsr_gen.sv | 102 ++++++++++
 tb/tb_lfsr_gen.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers: maximal-length tap table, lock-up state, seed sanitising.
// Used by lfsr_gen and lfsr_step.
package lfsr_pkg;

    localparam int N_MAX = 128;

    // Tap t maps to register index n-t, so tap n is always index 0.
    function automatic logic [N_MAX-1:0] tm(
        input int n,
        input int b,
        input int c = 0,
        input int d = 0,
        input int e = 0,
        input int f = 0
    );
        logic [N_MAX-1:0] m;
        m = N_MAX'(1);
        m |= N_MAX'(1) << (n - b);
        if (c > 0) m |= N_MAX'(1) << (n - c);
        if (d > 0) m |= N_MAX'(1) << (n - d);
        if (e > 0) m |= N_MAX'(1) << (n - e);
        if (f > 0) m |= N_MAX'(1) << (n - f);
        return m;
    endfunction

    function automatic logic [N_MAX-1:0] taps(input int n);
        logic [N_MAX-1:0] m;
        case (n)
            3:   m = tm(3, 2);
            4:   m = tm(4, 3);
            5:   m = tm(5, 3);
            6:   m = tm(6, 5);
            7:   m = tm(7, 6);
            8:   m = tm(8, 6, 5, 4);
            9:   m = tm(9, 5);
            10:  m = tm(10, 7);
            11:  m = tm(11, 9);
            12:  m = tm(12, 6, 4, 1);
            13:  m = tm(13, 4, 3, 1);
            14:  m = tm(14, 5, 3, 1);
            15:  m = tm(15, 14);
            16:  m = tm(16, 15, 13, 4);
            17:  m = tm(17, 14);
            18:  m = tm(18, 11);
            19:  m = tm(19, 6, 2, 1);
            20:  m = tm(20, 17);
            21:  m = tm(21, 19);
            22:  m = tm(22, 21);
            23:  m = tm(23, 18);
            24:  m = tm(24, 23, 22, 17);
            25:  m = tm(25, 22);
            26:  m = tm(26, 6, 2, 1);
            27:  m = tm(27, 5, 2, 1);
            28:  m = tm(28, 25);
            29:  m = tm(29, 27);
            30:  m = tm(30, 6, 4, 1);
            31:  m = tm(31, 28);
            32:  m = tm(32, 22, 2, 1);
            33:  m = tm(33, 20);
            34:  m = tm(34, 27, 2, 1);
            35:  m = tm(35, 33);
            36:  m = tm(36, 25);
            37:  m = tm(37, 5, 4, 3, 2, 1);
            38:  m = tm(38, 6, 5, 1);
            39:  m = tm(39, 35);
            40:  m = tm(40, 38, 21, 19);
            41:  m = tm(41, 38);
            42:  m = tm(42, 41, 20, 19);
            43:  m = tm(43, 42, 38, 37);
            44:  m = tm(44, 43, 18, 17);
            45:  m = tm(45, 44, 42, 41);
            46:  m = tm(46, 45, 26, 25);
            47:  m = tm(47, 42);
            48:  m = tm(48, 47, 21, 20);
            49:  m = tm(49, 40);
            50:  m = tm(50, 49, 24, 23);
            51:  m = tm(51, 50, 36, 35);
            52:  m = tm(52, 49);
            53:  m = tm(53, 52, 38, 37);
            54:  m = tm(54, 53, 18, 17);
            55:  m = tm(55, 31);
            56:  m = tm(56, 55, 35, 34);
            57:  m = tm(57, 50);
            58:  m = tm(58, 39);
            59:  m = tm(59, 58, 38, 37);
            60:  m = tm(60, 59);
            61:  m = tm(61, 60, 46, 45);
            62:  m = tm(62, 61, 6, 5);
            63:  m = tm(63, 62);
            64:  m = tm(64, 63, 61, 60);
            65:  m = tm(65, 47);
            66:  m = tm(66, 65, 57, 56);
            67:  m = tm(67, 66, 58, 57);
            68:  m = tm(68, 59);
            69:  m = tm(69, 67, 42, 40);
            70:  m = tm(70, 69, 55, 54);
            71:  m = tm(71, 65);
            72:  m = tm(72, 66, 25, 19);
            73:  m = tm(73, 48);
            74:  m = tm(74, 73, 59, 58);
            75:  m = tm(75, 74, 65, 64);
            76:  m = tm(76, 75, 41, 40);
            77:  m = tm(77, 76, 47, 46);
            78:  m = tm(78, 77, 59, 58);
            79:  m = tm(79, 70);
            80:  m = tm(80, 79, 43, 42);
            81:  m = tm(81, 77);
            82:  m = tm(82, 79, 47, 44);
            83:  m = tm(83, 82, 38, 37);
            84:  m = tm(84, 71);
            85:  m = tm(85, 84, 58, 57);
            86:  m = tm(86, 85, 74, 73);
            87:  m = tm(87, 74);
            88:  m = tm(88, 87, 17, 16);
            89:  m = tm(89, 51);
            90:  m = tm(90, 89, 72, 71);
            91:  m = tm(91, 90, 8, 7);
            92:  m = tm(92, 91, 80, 79);
            93:  m = tm(93, 91);
            94:  m = tm(94, 73);
            95:  m = tm(95, 84);
            96:  m = tm(96, 94, 49, 47);
            97:  m = tm(97, 91);
            98:  m = tm(98, 87);
            99:  m = tm(99, 97, 54, 52);
            100: m = tm(100, 63);
            101: m = tm(101, 100, 95, 94);
            102: m = tm(102, 101, 36, 35);
            103: m = tm(103, 94);
            104: m = tm(104, 103, 94, 93);
            105: m = tm(105, 89);
            106: m = tm(106, 91);
            107: m = tm(107, 105, 44, 42);
            108: m = tm(108, 77);
            109: m = tm(109, 108, 103, 102);
            110: m = tm(110, 109, 98, 97);
            111: m = tm(111, 101);
            112: m = tm(112, 110, 69, 67);
            113: m = tm(113, 104);
            114: m = tm(114, 113, 33, 32);
            115: m = tm(115, 114, 101, 100);
            116: m = tm(116, 115, 46, 45);
            117: m = tm(117, 115, 99, 97);
            118: m = tm(118, 85);
            119: m = tm(119, 111);
            120: m = tm(120, 113, 9, 2);
            121: m = tm(121, 103);
            122: m = tm(122, 121, 63, 62);
            123: m = tm(123, 121);
            124: m = tm(124, 87);
            125: m = tm(125, 124, 18, 17);
            126: m = tm(126, 125, 90, 89);
            127: m = tm(127, 126);
            128: m = tm(128, 126, 101, 99);
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [N_MAX-1:0] lockup(
        input int n,
        input bit xnor_mode
    );
        return xnor_mode ? ({N_MAX{1'b1}} >> (N_MAX - n)) : '0;
    endfunction

    // The lock-up seed is replaced by its nearest legal neighbour (bit 0 flipped).
    function automatic logic [N_MAX-1:0] sanitise(
        input int n,
        input bit xnor_mode,
        input logic [N_MAX-1:0] seed
    );
        logic [N_MAX-1:0] l;
        l = lockup(n, xnor_mode);
        if (seed != l) return seed;
        return l ^ N_MAX'(1);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational W-step advance of a right-shifting Fibonacci LFSR.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int N    = 32,
    parameter int W    = 8,
    parameter int XNOR = 0
) (
    input  logic [N-1:0] cur,
    output logic [N-1:0] nxt
);

    localparam logic [N-1:0] MASK = N'(taps(N));

    logic [N-1:0] r;
    logic         fb;

    always_comb begin
        r  = cur;
        fb = 1'b0;
        for (int i = 0; i < W; i++) begin
            fb = ^(r & MASK) ^ (XNOR != 0);
            r  = {fb, r[N-1:1]};
        end
        nxt = r;
    end

endmodule

// File: rtl/lfsr_gen.sv
// LFSR pattern generator with valid/ready beats and guarded reseed.
// Define LFSR_GEN_CHECK_EN to add the receive-side pattern checker.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int          N    = 32,
    parameter int          W    = 8,
    parameter int          XNOR = 0,
    parameter logic [N-1:0] SEED = {{(N-1){1'b0}}, 1'b1}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [N-1:0] seed_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [N-1:0] state_o,
    output logic         seed_err_o,
    output logic [31:0]  step_cnt_o
`ifdef LFSR_GEN_CHECK_EN
    ,
    input  logic         chk_valid_i,
    input  logic [W-1:0] chk_data_i,
    output logic         chk_err_o,
    output logic [15:0]  chk_err_cnt_o
`endif
);

    if (N < 3 || N > N_MAX || W < 1 || W > N) begin : g_bad_cfg
        $error("lfsr_gen: N must be 3..128 and W 1..N");
    end

    localparam logic [N-1:0] LOCK = N'(lockup(N, XNOR != 0));
    localparam logic [N-1:0] RST  = N'(sanitise(N, XNOR != 0, N_MAX'(SEED)));

    logic [N-1:0] state_q;
    logic [N-1:0] state_nxt;
    logic [N-1:0] seed_san;

    assign seed_san = N'(sanitise(N, XNOR != 0, N_MAX'(seed_i)));

    lfsr_step #(.N(N), .W(W), .XNOR(XNOR)) u_step (
        .cur (state_q),
        .nxt (state_nxt)
    );

    // A load wins over a coincident transfer and costs one bubble beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RST;
            out_valid  <= 1'b0;
            seed_err_o <= 1'b0;
            step_cnt_o <= '0;
        end else if (load_i) begin
            state_q    <= seed_san;
            out_valid  <= 1'b0;
            seed_err_o <= (seed_i == LOCK);
            step_cnt_o <= '0;
        end else begin
            out_valid  <= 1'b1;
            seed_err_o <= 1'b0;
            if (out_valid && out_ready) begin
                state_q    <= state_nxt;
                step_cnt_o <= step_cnt_o + 32'd1;
            end
        end
    end

    assign out_data = state_q[W-1:0];
    assign state_o  = state_q;

`ifdef LFSR_GEN_CHECK_EN
    logic [N-1:0] chk_q;
    logic [N-1:0] chk_nxt;

    lfsr_step #(.N(N), .W(W), .XNOR(XNOR)) u_chk_step (
        .cur (chk_q),
        .nxt (chk_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chk_q         <= RST;
            chk_err_o     <= 1'b0;
            chk_err_cnt_o <= '0;
        end else if (load_i) begin
            chk_q         <= seed_san;
            chk_err_o     <= 1'b0;
            chk_err_cnt_o <= '0;
        end else if (chk_valid_i) begin
            chk_q <= chk_nxt;
            if (chk_data_i != chk_q[W-1:0]) begin
                chk_err_o <= 1'b1;
                if (chk_err_cnt_o != 16'hFFFF)
                    chk_err_cnt_o <= chk_err_cnt_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Randomised bench for lfsr_gen against a bit-stream reference model.
// Checker phase runs only when LFSR_GEN_CHECK_EN is defined.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // dut a: N=4 W=1 XOR
    logic rst_a, ld_a, rdy_a, vld_a, err_a;
    logic [3:0] sd_a, st_a;
    logic [0:0] dat_a;
    logic [31:0] cnt_a;
    // dut b: N=4 W=4 XOR
    logic rst_b, ld_b, rdy_b, vld_b, err_b;
    logic [3:0] sd_b, st_b, dat_b;
    logic [31:0] cnt_b;
    // dut c: N=128 W=32 XNOR
    logic rst_c, ld_c, rdy_c, vld_c, err_c;
    logic [127:0] sd_c, st_c;
    logic [31:0] dat_c, cnt_c;
`ifdef LFSR_GEN_CHECK_EN
    logic cv_a, ce_a, cv_b, ce_b, cv_c, ce_c;
    logic [0:0] cd_a;
    logic [3:0] cd_b;
    logic [31:0] cd_c;
    logic [15:0] cc_a, cc_b, cc_c;
`endif

    lfsr_gen #(.N(4), .W(1), .XNOR(0), .SEED(4'h1)) u_a (
        .clk(clk), .rst_n(rst_a), .load_i(ld_a), .seed_i(sd_a),
        .out_valid(vld_a), .out_ready(rdy_a), .out_data(dat_a),
        .state_o(st_a), .seed_err_o(err_a), .step_cnt_o(cnt_a)
`ifdef LFSR_GEN_CHECK_EN
        , .chk_valid_i(cv_a), .chk_data_i(cd_a),
        .chk_err_o(ce_a), .chk_err_cnt_o(cc_a)
`endif
    );

    lfsr_gen #(.N(4), .W(4), .XNOR(0), .SEED(4'h1)) u_b (
        .clk(clk), .rst_n(rst_b), .load_i(ld_b), .seed_i(sd_b),
        .out_valid(vld_b), .out_ready(rdy_b), .out_data(dat_b),
        .state_o(st_b), .seed_err_o(err_b), .step_cnt_o(cnt_b)
`ifdef LFSR_GEN_CHECK_EN
        , .chk_valid_i(cv_b), .chk_data_i(cd_b),
        .chk_err_o(ce_b), .chk_err_cnt_o(cc_b)
`endif
    );

    lfsr_gen #(.N(128), .W(32), .XNOR(1), .SEED({128{1'b1}})) u_c (
        .clk(clk), .rst_n(rst_c), .load_i(ld_c), .seed_i(sd_c),
        .out_valid(vld_c), .out_ready(rdy_c), .out_data(dat_c),
        .state_o(st_c), .seed_err_o(err_c), .step_cnt_o(cnt_c)
`ifdef LFSR_GEN_CHECK_EN
        , .chk_valid_i(cv_c), .chk_data_i(cd_c),
        .chk_err_o(ce_c), .chk_err_cnt_o(cc_c)
`endif
    );

    // N=4 output bit stream from seed 1; the register is the next 4 bits.
    bit seq [15] = '{1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1};
    logic [3:0] beats5 [5] = '{4'h1, 4'h9, 4'h5, 4'hF, 4'h8};

    function automatic logic [3:0] win(input int p);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) v[i] = seq[(p + i) % 15];
        return v;
    endfunction

    function automatic int pos_of(input logic [3:0] s);
        for (int p = 0; p < 15; p++)
            if (win(p) == s) return p;
        return 0;
    endfunction

    // N=128 XNOR model: bit sequence with s[k+128] = ~(s[k]^s[k+2]^s[k+27]^s[k+29]).
    bit mq [$];

    function automatic void mc_load(input logic [127:0] v);
        mq.delete();
        for (int i = 0; i < 128; i++) mq.push_back(v[i]);
    endfunction

    function automatic void mc_step(input int k);
        bit nb;
        for (int i = 0; i < k; i++) begin
            nb = ~(mq[0] ^ mq[2] ^ mq[27] ^ mq[29]);
            mq.push_back(nb);
            void'(mq.pop_front());
        end
    endfunction

    function automatic logic [127:0] mc_state();
        logic [127:0] v;
        for (int i = 0; i < 128; i++) v[i] = mq[i];
        return v;
    endfunction

    localparam logic [127:0] ONES = {128{1'b1}};

    int p, pb, mcnt, r;
    bit mv;
    logic [3:0] s4, e4;
    logic [127:0] v, e;

    initial begin
        {rst_a, rst_b, rst_c} = '0;
        {ld_a, ld_b, ld_c}    = '0;
        {rdy_a, rdy_b, rdy_c} = '0;
        sd_a = '0; sd_b = '0; sd_c = '0;
`ifdef LFSR_GEN_CHECK_EN
        {cv_a, cv_b, cv_c} = '0;
        cd_a = '0; cd_b = '0; cd_c = '0;
`endif
        tick; tick;
        check("rst_vld_a", vld_a, 1'b0);
        check("rst_st_a", st_a, 4'h1);
        check("rst_cnt_a", cnt_a, 0);
        check("rst_err_a", err_a, 1'b0);
        check("rst_st_c", st_c, {{127{1'b1}}, 1'b0});
        check("rst_vld_c", vld_c, 1'b0);
        {rst_a, rst_b, rst_c} = 3'b111;
        tick;
        check("vld_rise_a", vld_a, 1'b1);

        // W=1 stream, two full periods
        p = 0;
        for (int k = 0; k < 30; k++) begin
            check("seq_a", dat_a, seq[p % 15]);
            check("st_a", st_a, win(p));
            check("nz_a", st_a == 4'h0, 1'b0);
            rdy_a = 1'b1;
            tick;
            p++;
        end
        rdy_a = 1'b0;
        check("cnt30_a", cnt_a, 30);

        // W=4 beats, backpressure, random ready
        pb = 0;
        for (int k = 0; k < 5; k++) begin
            check("beat_b", dat_b, beats5[k]);
            rdy_b = 1'b1;
            tick;
            pb += 4;
        end
        rdy_b = 1'b0;
        check("cnt5_b", cnt_b, 5);
        for (int k = 0; k < 3; k++) begin
            tick;
            check("bp_dat_b", dat_b, win(pb));
            check("bp_st_b", st_b, win(pb));
        end
        mcnt = 5;
        for (int k = 0; k < 40; k++) begin
            check("rnd_b", dat_b, win(pb));
            r = int'($urandom_range(1, 0));
            rdy_b = r[0];
            tick;
            if (r[0]) begin pb += 4; mcnt++; end
        end
        check("rnd_cnt_b", cnt_b, mcnt);
        rdy_b = 1'b0;

        // load of lock-up seed coincident with handshake
        check("pre_ld_vld_a", vld_a, 1'b1);
        rdy_a = 1'b1; ld_a = 1'b1; sd_a = 4'h0;
        tick;
        check("ld_st_a", st_a, 4'h1);
        check("ld_err_a", err_a, 1'b1);
        check("ld_vld_a", vld_a, 1'b0);
        check("ld_cnt_a", cnt_a, 0);
        ld_a = 1'b0;
        tick;
        check("ld_vld2_a", vld_a, 1'b1);
        check("ld_err2_a", err_a, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("restart_a", dat_a, seq[k]);
            tick;
        end

        // held load
        ld_a = 1'b1; sd_a = 4'h5;
        for (int k = 0; k < 3; k++) begin
            tick;
            check("hold_vld_a", vld_a, 1'b0);
            check("hold_err_a", err_a, 1'b0);
        end
        ld_a = 1'b0;
        tick;
        check("hold_rel_a", vld_a, 1'b1);
        check("hold_st_a", st_a, 4'h5);

        // random reseeds on N=4
        for (int it = 0; it < 50; it++) begin
            s4 = 4'($urandom_range(15, 0));
            e4 = (s4 == 4'h0) ? 4'h1 : s4;
            ld_a = 1'b1; sd_a = s4;
            rdy_a = 1'($urandom_range(1, 0));
            tick;
            ld_a = 1'b0;
            check("rs_st_a", st_a, e4);
            check("rs_err_a", err_a, s4 == 4'h0);
            p = pos_of(e4); mv = 1'b0; mcnt = 0;
            for (int j = 0; j < 5; j++) begin
                check("rs_seq_a", st_a, win(p));
                r = int'($urandom_range(1, 0));
                rdy_a = r[0];
                tick;
                if (mv && r[0]) begin p++; mcnt++; end
                mv = 1'b1;
                check("rs_vld_a", vld_a, 1'b1);
            end
            check("rs_cnt_a", cnt_a, mcnt);
        end

        // reset overrides load and transfer
        rdy_a = 1'b1; ld_a = 1'b1; sd_a = 4'h7; rst_a = 1'b0;
        tick;
        check("mrst_st_a", st_a, 4'h1);
        check("mrst_vld_a", vld_a, 1'b0);
        check("mrst_cnt_a", cnt_a, 0);
        check("mrst_err_a", err_a, 1'b0);
        rst_a = 1'b1; ld_a = 1'b0;
        tick;
        check("mrst_rel_a", vld_a, 1'b1);
        rdy_a = 1'b0;

        // N=128 XNOR long run: 3125 beats of 32 steps
        mc_load({{127{1'b1}}, 1'b0});
        rdy_c = 1'b1;
        for (int k = 0; k < 3125; k++) begin
            check("run_st_c", st_c, mc_state());
            check("run_lock_c", st_c == ONES, 1'b0);
            tick;
            mc_step(32);
        end
        rdy_c = 1'b0;
        check("run_cnt_c", cnt_c, 3125);
        check("run_end_c", st_c, mc_state());

        // random reseeds on N=128
        for (int it = 0; it < 1000; it++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(7, 0) == 0) v = ONES;
            e = (v == ONES) ? {{127{1'b1}}, 1'b0} : v;
            ld_c = 1'b1; sd_c = v;
            rdy_c = 1'($urandom_range(1, 0));
            tick;
            ld_c = 1'b0;
            mc_load(e);
            check("rs_st_c", st_c, e);
            check("rs_err_c", err_c, v == ONES);
            check("rs_vld_c", vld_c, 1'b0);
            check("rs_cnt_c", cnt_c, 0);
            mv = 1'b0; mcnt = 0;
            for (int j = 0; j < 2; j++) begin
                r = int'($urandom_range(1, 0));
                rdy_c = r[0];
                tick;
                if (mv && r[0]) begin mc_step(32); mcnt++; end
                mv = 1'b1;
            end
            check("rs_run_c", st_c, mc_state());
            check("rs_rcnt_c", cnt_c, mcnt);
        end
        rdy_c = 1'b0;

`ifdef LFSR_GEN_CHECK_EN
        ld_b = 1'b1; sd_b = 4'h1;
        tick;
        ld_b = 1'b0;
        tick;
        check("chk_clr_b", ce_b, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k == 7) check("chk_pre7_b", ce_b, 1'b0);
            rdy_b = 1'b1; cv_b = 1'b1;
            cd_b = dat_b ^ ((k == 7) ? 4'h1 : 4'h0);
            tick;
        end
        check("chk_err_b", ce_b, 1'b1);
        check("chk_cnt_b", cc_b, 16'd1);
        for (int k = 0; k < 70000; k++) begin
            cd_b = ~dat_b;
            tick;
        end
        check("chk_sat_b", cc_b, 16'hFFFF);
        cv_b = 1'b0; rdy_b = 1'b0; ld_b = 1'b1;
        tick;
        ld_b = 1'b0;
        check("chk_ld_err_b", ce_b, 1'b0);
        check("chk_ld_cnt_b", cc_b, 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
